// File: rtl/gray_counter_param.sv
// gray_counter_param: registered up/down Gray-code counter with synchronous
// Gray-coded load and a one-cycle wrap pulse. The binary count is the only
// real state; the Gray bus is registered from the next binary value so it is
// glitch-free and changes one bit per step (safe as a cross-domain pointer).
//
// Build option GRAY_COUNTER_SATURATE_EN: when defined the counter saturates
// at the ends of its range instead of wrapping, and wrap pulses on every
// enabled cycle whose step is blocked.
module gray_counter_param #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;
    logic             at_max, at_min;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(load_gray >> i);
        end
    end

    assign at_max = &bin_q;
    assign at_min = ~|bin_q;

    // Next count: load beats count, count beats hold; Gray follows next binary.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up) begin
`ifdef GRAY_COUNTER_SATURATE_EN
                if (at_max) wrap_d = 1'b1;
                else        bin_d  = bin_q + ONE;
`else
                bin_d  = bin_q + ONE;
                wrap_d = at_max;
`endif
            end else begin
`ifdef GRAY_COUNTER_SATURATE_EN
                if (at_min) wrap_d = 1'b1;
                else        bin_d  = bin_q - ONE;
`else
                bin_d  = bin_q - ONE;
                wrap_d = at_min;
`endif
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Testbench for gray_counter_param (WIDTH=4): directed sequences with literal
// expectations plus randomized traffic, all compared every cycle against a
// plain-arithmetic model of the counter.
module tb_gray_counter_param;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst, en, up, load;
    logic [W-1:0] load_gray;
    logic [W-1:0] gray_out, bin_out;
    logic         wrap;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [W-1:0] m_bin     = '0;
    logic         m_wrap    = 1'b0;
    logic         m_stepped = 1'b0;
    logic         m_valid   = 1'b0;
    logic [W-1:0] prev_gray = '0;

    gray_counter_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_gray (load_gray),
        .gray_out  (gray_out),
        .bin_out   (bin_out),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Binary value whose Gray code equals g, found by exhaustive search.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int v = 0; v <= MAXV; v++) begin
            b = W'(v);
            if ((b ^ (b >> 1)) == g) return b;
        end
        return '0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic u,
                              input logic l, input logic [W-1:0] lg);
        m_stepped = 1'b0;
        m_wrap    = 1'b0;
        if (r) begin
            m_bin   = '0;
            m_valid = 1'b1;
        end else if (l) begin
            m_bin = g2b(lg);
        end else if (e) begin
            if (u) begin
                if (int'(m_bin) == MAXV) begin
                    m_wrap = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
                    m_bin = '0;
                    m_stepped = 1'b1;
`endif
                end else begin
                    m_bin = W'(int'(m_bin) + 1);
                    m_stepped = 1'b1;
                end
            end else begin
                if (int'(m_bin) == 0) begin
                    m_wrap = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
                    m_bin = W'(MAXV);
                    m_stepped = 1'b1;
`endif
                end else begin
                    m_bin = W'(int'(m_bin) - 1);
                    m_stepped = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [W-1:0] lg);
        rst = r; en = e; up = u; load = l; load_gray = lg;
        @(posedge clk);
        model_step(r, e, u, l, lg);
        @(negedge clk);
        if (m_valid) begin
            chk("bin_out",  int'(bin_out),  int'(m_bin));
            chk("gray_out", int'(gray_out), int'(m_bin ^ (m_bin >> 1)));
            chk("wrap",     int'(wrap),     int'(m_wrap));
            chk("gray_inv", int'(gray_out), int'(bin_out ^ (bin_out >> 1)));
            if (m_stepped)
                chk("one_bit_toggle", $countones(gray_out ^ prev_gray), 1);
        end
        prev_gray = gray_out;
    endtask

    int up_seq [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_gray = '0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, '0);
        chk("rst_bin", int'(bin_out), 0);
        chk("rst_gray", int'(gray_out), 0);
        chk("rst_wrap", int'(wrap), 0);

        // 16 up steps from zero
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 1, 0, '0);
`ifdef GRAY_COUNTER_SATURATE_EN
            chk("up_seq_gray", int'(gray_out), (i == 15) ? 8 : up_seq[i]);
            chk("up_seq_wrap", int'(wrap), (i == 15) ? 1 : 0);
`else
            chk("up_seq_gray", int'(gray_out), up_seq[i]);
            chk("up_seq_wrap", int'(wrap), (i == 15) ? 1 : 0);
`endif
        end

        // Down step from zero
        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
`ifdef GRAY_COUNTER_SATURATE_EN
        chk("down0_bin", int'(bin_out), 0);
        chk("down0_gray", int'(gray_out), 0);
`else
        chk("down0_bin", int'(bin_out), 15);
        chk("down0_gray", int'(gray_out), 8);
`endif
        chk("down0_wrap", int'(wrap), 1);

        // Gray load, then one up step
        cyc(0, 0, 0, 1, 4'b1101);
        chk("load_bin", int'(bin_out), 9);
        chk("load_gray", int'(gray_out), 13);
        chk("load_wrap", int'(wrap), 0);
        cyc(0, 1, 1, 0, '0);
        chk("load_up_gray", int'(gray_out), 15);
        chk("load_up_bin", int'(bin_out), 10);

        // Load wins over enable
        cyc(0, 1, 1, 1, 4'b0110);
        chk("load_en_gray", int'(gray_out), 6);
        chk("load_en_bin", int'(bin_out), 4);

        // Reset mid-count with en held high
        cyc(1, 0, 0, 0, '0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, '0);
        chk("count7_bin", int'(bin_out), 7);
        cyc(1, 1, 1, 0, '0);
        chk("midrst_bin", int'(bin_out), 0);
        chk("midrst_gray", int'(gray_out), 0);
        cyc(0, 1, 1, 0, '0);
        chk("after_rst_bin", int'(bin_out), 1);
        chk("after_rst_gray", int'(gray_out), 1);

        // Up steps held at the top of the range
        cyc(0, 0, 0, 1, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, '0);
`ifdef GRAY_COUNTER_SATURATE_EN
            chk("sat_bin", int'(bin_out), 15);
            chk("sat_gray", int'(gray_out), 8);
            chk("sat_wrap", int'(wrap), 1);
`else
            chk("top_bin", int'(bin_out), i);
            chk("top_wrap", int'(wrap), (i == 0) ? 1 : 0);
`endif
        end

        // Direction change without a bubble
        cyc(0, 0, 0, 1, 4'b0011);
        cyc(0, 1, 0, 0, '0);
        chk("dir_down_bin", int'(bin_out), 1);
        cyc(0, 1, 1, 0, '0);
        chk("dir_up_bin", int'(bin_out), 2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 75),
                ($urandom_range(0, 99) < 55),
                ($urandom_range(0, 99) < 8),
                W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
